// File: rtl/dwnstrm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dwnstrm_pkg
//  Description : Shared op codes, status codes, FSM state encoding and a
//                helper for deriving the client-ID width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package dwnstrm_pkg;

    typedef enum logic [1:0] {
        OP_ORDER  = 2'b00,
        OP_CANCEL = 2'b01,
        OP_QUERY  = 2'b10,
        OP_RSVD   = 2'b11   // decoded exactly like OP_QUERY
    } op_e;

    typedef enum logic [1:0] {
        STAT_OK     = 2'b00,
        STAT_SAT    = 2'b01,
        STAT_REJECT = 2'b10,
        STAT_BADID  = 2'b11
    } status_e;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    // Client-ID width: $clog2 of the client count, never below one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwnstrm_cancel_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : dwnstrm_cancel_tracker_if
//  Description : Request/result bundle of the cancel tracker.
//  Ports       : in_valid/in_ready handshake, in_op, in_client_id (ID_W+1),
//                in_amount; out_valid pulse, out_client_id, out_balance,
//                out_cancelled, out_status.
//                master = request source, slave = tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dwnstrm_cancel_tracker_if #(
    parameter int NUM_CLIENTS = 32,
    parameter int AMOUNT_W    = 16,
    parameter int CNT_W       = 16
) ();
    import dwnstrm_pkg::*;

    localparam int ID_W = id_width(NUM_CLIENTS);

    logic                in_valid;
    logic                in_ready;
    op_e                 in_op;
    logic [ID_W:0]       in_client_id;
    logic [AMOUNT_W-1:0] in_amount;

    logic                out_valid;
    logic [ID_W:0]       out_client_id;
    logic [AMOUNT_W-1:0] out_balance;
    logic [CNT_W-1:0]    out_cancelled;
    status_e             out_status;

    modport master (
        output in_valid, in_op, in_client_id, in_amount,
        input  in_ready,
        input  out_valid, out_client_id, out_balance, out_cancelled, out_status
    );

    modport slave (
        input  in_valid, in_op, in_client_id, in_amount,
        output in_ready,
        output out_valid, out_client_id, out_balance, out_cancelled, out_status
    );

endinterface
`default_nettype wire

// File: rtl/dwnstrm_sat_alu.sv
`default_nettype none
// ============================================================================
//  Module      : dwnstrm_sat_alu
//  Description : Saturating add / checked subtract on a client balance.
//  Ports       : i_balance, i_amount (AMOUNT_W), i_sub (1 = subtract);
//                o_result, o_sat (add overflowed, result clamped to all-ones),
//                o_borrow (subtract would underflow, result = i_balance).
//  Revision    : 1.0 - initial release
// ============================================================================
module dwnstrm_sat_alu #(
    parameter int AMOUNT_W = 16
) (
    input  wire logic [AMOUNT_W-1:0] i_balance,
    input  wire logic [AMOUNT_W-1:0] i_amount,
    input  wire logic                i_sub,
    output logic      [AMOUNT_W-1:0] o_result,
    output logic                     o_sat,
    output logic                     o_borrow
);

    logic [AMOUNT_W:0] w_sum;

    assign w_sum = {1'b0, i_balance} + {1'b0, i_amount};

    always_comb begin
        o_result = i_balance;
        o_sat    = 1'b0;
        o_borrow = 1'b0;
        if (i_sub) begin
            if (i_amount > i_balance) begin
                o_borrow = 1'b1;
            end else begin
                o_result = i_balance - i_amount;
            end
        end else if (w_sum[AMOUNT_W]) begin
            o_sat    = 1'b1;
            o_result = '1;
        end else begin
            o_result = w_sum[AMOUNT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dwnstrm_cancel_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : dwnstrm_cancel_tracker
//  Description : Per-client balance and cancel-count table with ORDER /
//                CANCEL / QUERY requests, one-cycle result latency, a global
//                accepted-cancel counter and a one-entry-per-cycle table wipe.
//  Ports       : clk, rst_n (synchronous, active low)
//                bus              : request/result interface (slave side)
//                cancelled_orders : running total of accepted cancels
//                clear_req        : start a table wipe (ignored while wiping)
//                clear_busy       : high for each of the NUM_CLIENTS wipe cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module dwnstrm_cancel_tracker
    import dwnstrm_pkg::*;
#(
    parameter int NUM_CLIENTS = 32,
    parameter int AMOUNT_W    = 16,
    parameter int CNT_W       = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    dwnstrm_cancel_tracker_if.slave   bus,
    output logic      [CNT_W-1:0]     cancelled_orders,
    input  wire logic                 clear_req,
    output logic                      clear_busy
);

    localparam int              ID_W       = id_width(NUM_CLIENTS);
    localparam logic [ID_W:0]   c_NUM_ID   = (ID_W + 1)'(NUM_CLIENTS);
    localparam logic [ID_W-1:0] c_LAST_IDX = ID_W'(NUM_CLIENTS - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ID_W-1:0]     r_sweep_idx;

    logic [AMOUNT_W-1:0] r_balance [NUM_CLIENTS];
    logic [CNT_W-1:0]    r_ccount  [NUM_CLIENTS];
    logic [CNT_W-1:0]    r_cancel_total;

    logic                w_accept;
    logic                w_id_ok;
    logic [ID_W-1:0]     w_idx;
    logic [AMOUNT_W-1:0] w_cur_bal;
    logic [CNT_W-1:0]    w_cur_cnt;
    logic [AMOUNT_W-1:0] w_alu_res;
    logic                w_alu_sat;
    logic                w_alu_borrow;
    logic [AMOUNT_W-1:0] w_new_bal;
    logic [CNT_W-1:0]    w_new_cnt;
    logic                w_write;
    logic                w_count_cancel;
    status_e             w_status;

    assign bus.in_ready     = (r_state == S_IDLE) && !clear_req;
    assign w_accept         = bus.in_valid && bus.in_ready;
    assign w_idx            = bus.in_client_id[ID_W-1:0];
    assign w_id_ok          = (bus.in_client_id < c_NUM_ID);
    assign w_cur_bal        = w_id_ok ? r_balance[w_idx] : '0;
    assign w_cur_cnt        = w_id_ok ? r_ccount[w_idx]  : '0;
    assign clear_busy       = (r_state == S_CLEAR);
    assign cancelled_orders = r_cancel_total;

    dwnstrm_sat_alu #(
        .AMOUNT_W (AMOUNT_W)
    ) u_alu (
        .i_balance (w_cur_bal),
        .i_amount  (bus.in_amount),
        .i_sub     (bus.in_op == OP_CANCEL),
        .o_result  (w_alu_res),
        .o_sat     (w_alu_sat),
        .o_borrow  (w_alu_borrow)
    );

    // Decode of the request; w_write / w_count_cancel only take effect when
    // the request is actually transferred.
    always_comb begin
        w_status       = STAT_OK;
        w_new_bal      = w_cur_bal;
        w_new_cnt      = w_cur_cnt;
        w_write        = 1'b0;
        w_count_cancel = 1'b0;
        if (!w_id_ok) begin
            w_status = STAT_BADID;
        end else begin
            case (bus.in_op)
                OP_ORDER: begin
                    w_new_bal = w_alu_res;
                    w_write   = 1'b1;
                    if (w_alu_sat) w_status = STAT_SAT;
                end
                OP_CANCEL: begin
                    if (w_alu_borrow) begin
                        w_status = STAT_REJECT;
                    end else begin
                        w_new_bal      = w_alu_res;
                        w_new_cnt      = (w_cur_cnt == '1) ? w_cur_cnt : w_cur_cnt + 1'b1;
                        w_write        = 1'b1;
                        w_count_cancel = 1'b1;
                    end
                end
                default: ;  // QUERY and reserved: read only
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clear_req) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_sweep_idx == c_LAST_IDX) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The sweep index wraps to zero on the last entry so the next wipe
    // starts from entry 0 without extra bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sweep_idx <= '0;
        end else if (r_state == S_CLEAR) begin
            r_sweep_idx <= (r_sweep_idx == c_LAST_IDX) ? '0 : r_sweep_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                r_balance[i] <= '0;
                r_ccount[i]  <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            r_balance[r_sweep_idx] <= '0;
            r_ccount[r_sweep_idx]  <= '0;
        end else if (w_accept && w_write) begin
            r_balance[w_idx] <= w_new_bal;
            r_ccount[w_idx]  <= w_new_cnt;
        end
    end

    // Sweep index is 0 only on the first wipe cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cancel_total <= '0;
        end else if ((r_state == S_CLEAR) && (r_sweep_idx == '0)) begin
            r_cancel_total <= '0;
        end else if (w_accept && w_count_cancel && (r_cancel_total != '1)) begin
            r_cancel_total <= r_cancel_total + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid     <= 1'b0;
            bus.out_client_id <= '0;
            bus.out_balance   <= '0;
            bus.out_cancelled <= '0;
            bus.out_status    <= STAT_OK;
        end else begin
            bus.out_valid <= w_accept;
            if (w_accept) begin
                bus.out_client_id <= bus.in_client_id;
                bus.out_balance   <= w_new_bal;
                bus.out_cancelled <= w_new_cnt;
                bus.out_status    <= w_status;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dwnstrm_cancel_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dwnstrm_cancel_tracker
//  Description : Directed self-checking bench for dwnstrm_cancel_tracker.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dwnstrm_cancel_tracker;
    import dwnstrm_pkg::*;

    localparam int NUM_CLIENTS = 32;
    localparam int AMOUNT_W    = 16;
    localparam int CNT_W       = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear_req;
    logic             clear_busy;
    logic [CNT_W-1:0] cancelled_orders;

    int errors = 0;
    int checks = 0;

    dwnstrm_cancel_tracker_if #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .AMOUNT_W    (AMOUNT_W),
        .CNT_W       (CNT_W)
    ) bus ();

    dwnstrm_cancel_tracker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .AMOUNT_W    (AMOUNT_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .cancelled_orders (cancelled_orders),
        .clear_req        (clear_req),
        .clear_busy       (clear_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single edge; outputs are valid on return.
    task automatic do_op(input op_e op, input int id, input int amt);
        bus.in_valid     = 1'b1;
        bus.in_op        = op;
        bus.in_client_id = 6'(id);
        bus.in_amount    = 16'(amt);
        @(posedge clk); #1;
        bus.in_valid     = 1'b0;
    endtask

    task automatic check_result(input string tag, input int id, input int bal,
                                input int cnt, input status_e st);
        check({tag, ".valid"},  32'(bus.out_valid), 32'd1);
        check({tag, ".id"},     32'(bus.out_client_id), 32'(id));
        check({tag, ".bal"},    32'(bus.out_balance), 32'(bal));
        check({tag, ".cnt"},    32'(bus.out_cancelled), 32'(cnt));
        check({tag, ".status"}, 32'(bus.out_status), 32'(st));
    endtask

    initial begin
        int n;
        int ready_viol;

        rst_n            = 1'b0;
        clear_req        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_op        = OP_QUERY;
        bus.in_client_id = '0;
        bus.in_amount    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid",  32'(bus.out_valid), 32'd0);
        check("rst.out_status", 32'(bus.out_status), 32'd0);
        check("rst.out_bal",    32'(bus.out_balance), 32'd0);
        check("rst.cancelled",  32'(cancelled_orders), 32'd0);
        check("rst.clear_busy", 32'(clear_busy), 32'd0);
        check("rst.in_ready",   32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(OP_ORDER, 3, 100);
        check_result("order3", 3, 100, 0, STAT_OK);
        do_op(OP_CANCEL, 3, 40);
        check_result("cancel3a", 3, 60, 1, STAT_OK);
        check("cancel3a.total", 32'(cancelled_orders), 32'd1);
        do_op(OP_CANCEL, 3, 70);
        check_result("cancel3b", 3, 60, 1, STAT_REJECT);
        check("cancel3b.total", 32'(cancelled_orders), 32'd1);
        @(posedge clk); #1;
        check("pulse.out_valid", 32'(bus.out_valid), 32'd0);

        do_op(OP_ORDER, 5, 16'hFFF0);
        check_result("order5a", 5, 16'hFFF0, 0, STAT_OK);
        do_op(OP_ORDER, 5, 16'h0020);
        check_result("order5b", 5, 16'hFFFF, 0, STAT_SAT);
        do_op(OP_CANCEL, 5, 0);
        check_result("cancel5z", 5, 16'hFFFF, 1, STAT_OK);
        check("cancel5z.total", 32'(cancelled_orders), 32'd2);

        do_op(OP_QUERY, 40, 0);
        check_result("badid40", 40, 0, 0, STAT_BADID);
        do_op(OP_ORDER, 32, 7);
        check_result("badid32", 32, 0, 0, STAT_BADID);
        do_op(OP_QUERY, 3, 0);
        check_result("query3", 3, 60, 1, STAT_OK);
        do_op(OP_RSVD, 5, 9);
        check_result("rsvd5", 5, 16'hFFFF, 1, STAT_OK);
        check("rsvd5.total", 32'(cancelled_orders), 32'd2);

        // Back-to-back transfers on consecutive edges.
        bus.in_valid = 1'b1; bus.in_op = OP_ORDER; bus.in_client_id = 6'd7; bus.in_amount = 16'd1;
        @(posedge clk); #1;
        check_result("b2b.first", 7, 1, 0, STAT_OK);
        bus.in_amount = 16'd2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_result("b2b.second", 7, 3, 0, STAT_OK);

        do_op(OP_ORDER, 31, 9);
        check_result("order31", 31, 9, 0, STAT_OK);

        // Transfer immediately followed by a wipe request.
        do_op(OP_ORDER, 3, 5);
        clear_req = 1'b1;
        #1;
        check_result("preclear", 3, 65, 1, STAT_OK);
        check("clear_req.in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        clear_req  = 1'b0;
        n          = 0;
        ready_viol = 0;
        while (clear_busy && n < 100) begin
            if (bus.in_ready !== 1'b0) ready_viol++;
            n++;
            @(posedge clk); #1;
        end
        check("clear.busy_cycles", 32'(n), 32'd32);
        check("clear.ready_low", 32'(ready_viol), 32'd0);
        check("clear.total", 32'(cancelled_orders), 32'd0);
        check("clear.in_ready_after", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            do_op(OP_QUERY, i, 0);
            check_result($sformatf("wiped%0d", i), i, 0, 0, STAT_OK);
        end

        // Reset in the middle of a wipe.
        do_op(OP_ORDER, 30, 77);
        do_op(OP_CANCEL, 30, 7);
        check("pre_rst.total", 32'(cancelled_orders), 32'd1);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midclear.busy", 32'(clear_busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rstclr.busy",      32'(clear_busy), 32'd0);
        check("rstclr.in_ready",  32'(bus.in_ready), 32'd1);
        check("rstclr.out_valid", 32'(bus.out_valid), 32'd0);
        check("rstclr.total",     32'(cancelled_orders), 32'd0);
        do_op(OP_QUERY, 30, 0);
        check_result("rstclr.q30", 30, 0, 0, STAT_OK);
        do_op(OP_QUERY, 3, 0);
        check_result("rstclr.q3", 3, 0, 0, STAT_OK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
